// File: rtl/alu_muldiv_pkg.sv
// Shared opcode and FSM state definitions for the iterative multiply/divide unit.
// Op decode helpers keep the top's accept logic readable.
package alu_muldiv_pkg;

  localparam logic [2:0] MD_OP_MULT  = 3'b000;
  localparam logic [2:0] MD_OP_MULTU = 3'b001;
  localparam logic [2:0] MD_OP_DIV   = 3'b010;
  localparam logic [2:0] MD_OP_DIVU  = 3'b011;
  localparam logic [2:0] MD_OP_MTHI  = 3'b100;
  localparam logic [2:0] MD_OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_RUN  = 2'd1,
    MD_ST_FIX  = 2'd2
  } md_state_e;

  // MULT/MULTU/DIV/DIVU occupy the lower half of the opcode space
  function automatic logic md_is_arith(input logic [2:0] op);
    return !op[2];
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return !op[2] && !op[0];
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return !op[2] && op[1];
  endfunction

endpackage

// File: rtl/alu_muldiv_sign.sv
// Conditional two's-complement negate; used both for operand magnitudes and result sign fix-up.
module alu_muldiv_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one result bit per cycle.
// acc_hi/acc_lo double as {product} for multiply and {remainder, quotient} for divide.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            op,
  input  logic [WORD_WIDTH-1:0] a_input,
  input  logic [WORD_WIDTH-1:0] b_input,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [WORD_WIDTH-1:0] hi,
  output logic [WORD_WIDTH-1:0] lo
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  opnd_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
  logic          div_q, neg_res_q, neg_rem_q, dz_q, done_q, div_zero_q;

  logic [W-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [2*W-1:0] prod_fix;
  logic           sgn;
  logic [W:0]     mul_sum, div_sh;
  logic [W-1:0]   div_diff;
  logic           div_ge;

  assign sgn = md_is_signed(op);

  alu_muldiv_sign #(.W(W))   u_abs_a (.val(a_input), .neg(sgn & a_input[W-1]), .res(a_abs));
  alu_muldiv_sign #(.W(W))   u_abs_b (.val(b_input), .neg(sgn & b_input[W-1]), .res(b_abs));
  alu_muldiv_sign #(.W(2*W)) u_fix_p (.val({acc_hi_q, acc_lo_q}), .neg(neg_res_q), .res(prod_fix));
  alu_muldiv_sign #(.W(W))   u_fix_q (.val(acc_lo_q), .neg(neg_res_q), .res(quo_fix));
  alu_muldiv_sign #(.W(W))   u_fix_r (.val(acc_hi_q), .neg(neg_rem_q), .res(rem_fix));

  // Multiply: add multiplicand on LSB of multiplier, shift right.
  // Divide: shift remainder left pulling in dividend MSB, subtract if it fits.
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
  assign div_sh   = {acc_hi_q, acc_lo_q[W-1]};
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  assign div_diff = div_sh[W-1:0] - opnd_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_ST_IDLE: if (start && !flush && md_is_arith(op)) state_d = MD_ST_RUN;
      MD_ST_RUN:  if (flush) state_d = MD_ST_IDLE;
                  else if (cnt_q == '0) state_d = MD_ST_FIX;
      MD_ST_FIX:  state_d = MD_ST_IDLE;
      default:    state_d = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MD_ST_IDLE;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        MD_ST_IDLE: if (start && !flush) begin
          if (md_is_arith(op)) begin
            div_q     <= md_is_div(op);
            opnd_q    <= md_is_div(op) ? b_abs : a_abs;
            acc_hi_q  <= '0;
            acc_lo_q  <= md_is_div(op) ? a_abs : b_abs;
            neg_res_q <= sgn & (a_input[W-1] ^ b_input[W-1]);
            neg_rem_q <= sgn & a_input[W-1];
            cnt_q     <= CW'(W-1);
            if (md_is_div(op)) begin
              div_zero_q <= 1'b0;
              dz_q       <= (b_input == '0);
            end
          end else if (op == MD_OP_MTHI) hi_q <= a_input;
          else if (op == MD_OP_MTLO) lo_q <= a_input;
        end
        MD_ST_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (div_q) begin
            acc_hi_q <= div_ge ? div_diff : div_sh[W-1:0];
            acc_lo_q <= {acc_lo_q[W-2:0], div_ge};
          end else begin
            acc_hi_q <= mul_sum[W:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[W-1:1]};
          end
        end
        MD_ST_FIX: if (!flush) begin
          done_q <= 1'b1;
          if (div_q) begin
            // divide-by-zero: remainder path already reproduces a_input
            hi_q       <= rem_fix;
            lo_q       <= dz_q ? '1 : quo_fix;
            div_zero_q <= dz_q;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != MD_ST_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WORD_WIDTH=32 with hand-computed HI/LO results.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a_input, b_input;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int ncmp = 0;
  int nerr = 0;

  alu_muldiv #(.WORD_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .a_input(a_input), .b_input(b_input), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for done (bounded), check latency and HI/LO.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int lat;
    op = o; a_input = a; b_input = b; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (done) break;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_nbusy"}, 64'(busy), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    tick();
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b111; a_input = '0; b_input = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", {hi, lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);

    run_op("mult_neg",  MD_OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_mneg", MD_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_neg",   MD_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",      MD_OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3);
    run_op("div_100_7", MD_OP_DIV,   32'd100,      32'd7,        32'd2,        32'd14);
    run_op("div_wrap",  MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    chk("dz_clear", 64'(div_zero), 64'd0);
    run_op("divu_z",    MD_OP_DIVU,  32'h1234,     32'd0,        32'h00001234, 32'hFFFFFFFF);
    chk("dz_set", 64'(div_zero), 64'd1);
    run_op("div_z_neg", MD_OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    chk("dz_set2", 64'(div_zero), 64'd1);

    // DIV in flight: a later start is ignored, a flush aborts without touching HI/LO
    op = MD_OP_DIV; a_input = 32'd100; b_input = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dz_start_clr", 64'(div_zero), 64'd0);
    repeat (4) tick();
    op = MD_OP_MULT; a_input = 32'd3; b_input = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ign", 64'(busy), 64'd1);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {62'd0, busy, done}, 64'd0);
    chk("flush_hilo", {hi, lo}, {32'hFFFFFFFB, 32'hFFFFFFFF});
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("flush_nodone", 64'(ndone), 64'd0);
    chk("flush_hilo2", {hi, lo}, {32'hFFFFFFFB, 32'hFFFFFFFF});

    // flush and start together in IDLE: flush wins
    op = MD_OP_MULTU; a_input = 32'd5; b_input = 32'd5; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start", 64'(busy), 64'd0);

    op = MD_OP_MTHI; a_input = 32'hA5A5A5A5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mthi", {hi, lo}, {32'hA5A5A5A5, 32'hFFFFFFFF});
    chk("mthi_flags", {62'd0, busy, done}, 64'd0);
    op = MD_OP_MTLO; a_input = 32'h5A5A5A5A; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mtlo", {hi, lo}, {32'hA5A5A5A5, 32'h5A5A5A5A});
    chk("mtlo_flags", {62'd0, busy, done}, 64'd0);

    op = 3'b110; a_input = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nop", {hi, lo}, {32'hA5A5A5A5, 32'h5A5A5A5A});
    chk("nop_busy", 64'(busy), 64'd0);

    // reset mid-MULT discards the op
    op = MD_OP_MULT; a_input = 32'd5; b_input = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_flags", {61'd0, busy, done, div_zero}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("rst_mid_nodone", 64'(ndone), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
